pmp_csr_file: RTL and testbench

//  PMP configuration store feeding the PMP address/permission compare stage.

---
 rtl/pmp_csr_file.sv | 227 ++++++++++++++++++++++
 tb/tb_pmp_csr_file.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_csr_file.sv
// ---------------------------------------------------------------------------
// pmp_csr_file
//
// PMP configuration store feeding the PMP address/permission compare stage.
// Holds the pmpcfg0..7 / pmpaddr0..31 CSRs and applies the lock and WARL
// rules on writes. Serves a single-outstanding valid/ready CSR port and
// drives per-entry cfg, addr and NAPOT compare mask to the compare stage.
//
// Optional build macro: PMP_CSR_MASK_PIPE_EN
//   defined   : compare mask is registered and lags pmpaddr by one cycle;
//               o_pmp_upd_busy flags the cycle in which the mask is stale.
//   undefined : compare mask is combinational from pmpaddr; busy tied to 0.
//
// Parameters
//   PMP_CHANNEL_NUM  number of implemented entries (1..32)
//   ADDR_WIDTH       width of pmpaddr registers and compare masks
//
// Ports
//   i_clk               clock
//   i_rst               synchronous reset, active-high
//   i_csr_req_vld       CSR request valid
//   o_csr_req_rdy       CSR request ready (~rsp_vld | rsp_rdy)
//   i_csr_req_we        1 = write, 0 = read
//   i_csr_req_addr      12-bit CSR address
//   i_csr_req_wdata     write data
//   o_csr_rsp_vld       response valid, held until i_csr_rsp_rdy
//   i_csr_rsp_rdy       response accepted
//   o_csr_rsp_rdata     read data (0 for writes and errors)
//   o_csr_rsp_err       address is not a PMP CSR
//   o_v_pmp_cfg         per-entry cfg byte {L,2'b00,A[1:0],X,W,R}
//   o_v_pmp_addr        per-entry pmpaddr
//   o_v_pmp_napot_mask  per-entry compare mask, 1 = bit compared
//   o_pmp_upd_busy      mask stale this cycle; downstream must not trust pass
// ---------------------------------------------------------------------------
module pmp_csr_file #(
    parameter int PMP_CHANNEL_NUM = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_csr_req_vld,
    output logic                                         o_csr_req_rdy,
    input  logic                                         i_csr_req_we,
    input  logic [11:0]                                  i_csr_req_addr,
    input  logic [31:0]                                  i_csr_req_wdata,
    output logic                                         o_csr_rsp_vld,
    input  logic                                         i_csr_rsp_rdy,
    output logic [31:0]                                  o_csr_rsp_rdata,
    output logic                                         o_csr_rsp_err,
    output logic [PMP_CHANNEL_NUM-1:0][7:0]              o_v_pmp_cfg,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]   o_v_pmp_addr,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]   o_v_pmp_napot_mask,
    output logic                                         o_pmp_upd_busy
);

    localparam logic [11:0] CFG_BASE  = 12'h3A0;
    localparam logic [11:0] CFG_LAST  = 12'h3A7;
    localparam logic [11:0] ADDR_BASE = 12'h3B0;
    localparam logic [11:0] ADDR_LAST = 12'h3CF;
    localparam logic [1:0]  A_TOR     = 2'b01;

    // Compare mask: ones from bit 0 up to and including the first zero of
    // addr are "don't care"; the wrap of addr+1 makes all-ones addr match all.
    function automatic logic [ADDR_WIDTH-1:0] napot_mask(input logic [ADDR_WIDTH-1:0] a);
        return ~(a ^ (a + ADDR_WIDTH'(1)));
    endfunction

    // Architectural state
    logic [PMP_CHANNEL_NUM-1:0][7:0]            r_cfg;
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0] r_addr;
    logic                                       r_rsp_vld;
    logic [31:0]                                r_rsp_rdata;
    logic                                       r_rsp_err;

    // Request decode
    logic        w_req_rdy;
    logic        w_accept;
    logic        w_is_cfg;
    logic        w_is_addr;
    logic [2:0]  w_cfg_idx;
    logic [4:0]  w_addr_idx;
    logic        w_wr_cfg;
    logic        w_wr_addr;
    logic [31:0] w_rdata;

    // Per-entry write controls
    logic [PMP_CHANNEL_NUM-1:0]                 w_cfg_we;
    logic [PMP_CHANNEL_NUM-1:0][7:0]            w_cfg_new;
    logic [PMP_CHANNEL_NUM-1:0]                 w_addr_we;
    logic [PMP_CHANNEL_NUM-1:0]                 w_tor_lock_next;
    logic [ADDR_WIDTH-1:0]                      w_addr_new;

    // 32-entry views with unimplemented entries reading as zero
    logic [31:0][7:0]  w_cfg_pad;
    logic [31:0][31:0] w_addr_pad;

    assign w_req_rdy  = ~r_rsp_vld | i_csr_rsp_rdy;
    assign w_accept   = i_csr_req_vld & w_req_rdy;
    assign w_is_cfg   = (i_csr_req_addr >= CFG_BASE)  && (i_csr_req_addr <= CFG_LAST);
    assign w_is_addr  = (i_csr_req_addr >= ADDR_BASE) && (i_csr_req_addr <= ADDR_LAST);
    assign w_cfg_idx  = i_csr_req_addr[2:0];
    // 0x3B0 has low five bits 0x10, so the pmpaddr index is low bits minus 16 mod 32
    assign w_addr_idx = i_csr_req_addr[4:0] - 5'h10;
    assign w_wr_cfg   = w_accept & i_csr_req_we & w_is_cfg;
    assign w_wr_addr  = w_accept & i_csr_req_we & w_is_addr;
    assign w_addr_new = ADDR_WIDTH'(i_csr_req_wdata);

    genvar g;
    generate
        for (g = 0; g < 32; g++) begin : g_pad
            if (g < PMP_CHANNEL_NUM) begin : g_impl
                assign w_cfg_pad[g]  = r_cfg[g];
                assign w_addr_pad[g] = 32'(r_addr[g]);
            end else begin : g_unimpl
                assign w_cfg_pad[g]  = 8'h00;
                assign w_addr_pad[g] = 32'h0000_0000;
            end
        end

        for (g = 0; g < PMP_CHANNEL_NUM; g++) begin : g_entry
            // Entry g lives in byte g%4 of pmpcfg(g/4); bits 6:5 are dropped
            // and W without R is stored as W=0.
            assign w_cfg_new[g] = {i_csr_req_wdata[8*(g%4)+7],
                                   2'b00,
                                   i_csr_req_wdata[8*(g%4)+4 -: 2],
                                   i_csr_req_wdata[8*(g%4)+2],
                                   i_csr_req_wdata[8*(g%4)+1] & i_csr_req_wdata[8*(g%4)],
                                   i_csr_req_wdata[8*(g%4)]};
            assign w_cfg_we[g]  = w_wr_cfg & (w_cfg_idx == 3'(g / 4)) & ~r_cfg[g][7];

            // A locked TOR entry above also freezes this entry's pmpaddr,
            // since it is that entry's lower bound.
            if (g < PMP_CHANNEL_NUM - 1) begin : g_tor
                assign w_tor_lock_next[g] = r_cfg[g+1][7] & (r_cfg[g+1][4:3] == A_TOR);
            end else begin : g_no_tor
                assign w_tor_lock_next[g] = 1'b0;
            end
            assign w_addr_we[g] = w_wr_addr & (w_addr_idx == 5'(g)) &
                                  ~r_cfg[g][7] & ~w_tor_lock_next[g];
        end
    endgenerate

    // Read data mux for the addressed CSR
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_is_cfg) begin
            w_rdata = {w_cfg_pad[{w_cfg_idx, 2'd3}], w_cfg_pad[{w_cfg_idx, 2'd2}],
                       w_cfg_pad[{w_cfg_idx, 2'd1}], w_cfg_pad[{w_cfg_idx, 2'd0}]};
        end else if (w_is_addr) begin
            w_rdata = w_addr_pad[w_addr_idx];
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // Response register: loaded on accept, held until the consumer takes it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_vld   <= 1'b1;
            r_rsp_rdata <= i_csr_req_we ? 32'h0000_0000 : w_rdata;
            r_rsp_err   <= ~(w_is_cfg | w_is_addr);
        end else if (i_csr_rsp_rdy) begin
            r_rsp_vld   <= 1'b0;
        end
    end

    // PMP entry state; locks only clear through reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                r_cfg[i]  <= 8'h00;
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                if (w_cfg_we[i]) begin
                    r_cfg[i] <= w_cfg_new[i];
                end
                if (w_addr_we[i]) begin
                    r_addr[i] <= w_addr_new;
                end
            end
        end
    end

`ifdef PMP_CSR_MASK_PIPE_EN
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0] r_mask;
    logic                                       r_busy;

    // Registered mask trails pmpaddr by one cycle; busy marks that cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                r_mask[i] <= {ADDR_WIDTH{1'b1}} << 1;
            end
            r_busy <= 1'b0;
        end else begin
            for (int i = 0; i < PMP_CHANNEL_NUM; i++) begin
                r_mask[i] <= napot_mask(r_addr[i]);
            end
            r_busy <= |w_addr_we;
        end
    end

    assign o_v_pmp_napot_mask = r_mask;
    assign o_pmp_upd_busy     = r_busy;
`else
    generate
        for (g = 0; g < PMP_CHANNEL_NUM; g++) begin : g_mask
            assign o_v_pmp_napot_mask[g] = napot_mask(r_addr[g]);
        end
    endgenerate
    assign o_pmp_upd_busy = 1'b0;
`endif

    assign o_csr_req_rdy   = w_req_rdy;
    assign o_csr_rsp_vld   = r_rsp_vld;
    assign o_csr_rsp_rdata = r_rsp_rdata;
    assign o_csr_rsp_err   = r_rsp_err;
    assign o_v_pmp_cfg     = r_cfg;
    assign o_v_pmp_addr    = r_addr;

endmodule

// File: tb/tb_pmp_csr_file.sv
// ---------------------------------------------------------------------------
// tb_pmp_csr_file
//
// Directed self-checking bench for pmp_csr_file. One 32-entry instance covers
// decode, WARL, lock, TOR lock, mask, handshake and back-to-back behaviour;
// an 8-entry instance covers unimplemented entries and reset mid-response.
// Honours PMP_CSR_MASK_PIPE_EN for mask/busy timing.
// ---------------------------------------------------------------------------
module tb_pmp_csr_file;

`ifdef PMP_CSR_MASK_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_rdy = 1'b1;

    logic              vld32 = 1'b0, rdy32, rspv32, err32, busy32;
    logic [31:0]       rdata32;
    logic [31:0][7:0]  cfg32;
    logic [31:0][31:0] addr32, mask32;

    logic             vld8 = 1'b0, rdy8, rspv8, err8, busy8;
    logic [31:0]      rdata8;
    logic [7:0][7:0]  cfg8;
    logic [7:0][31:0] addr8, mask8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmp_csr_file #(.PMP_CHANNEL_NUM(32), .ADDR_WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst),
        .i_csr_req_vld(vld32), .o_csr_req_rdy(rdy32), .i_csr_req_we(req_we),
        .i_csr_req_addr(req_addr), .i_csr_req_wdata(req_wdata),
        .o_csr_rsp_vld(rspv32), .i_csr_rsp_rdy(rsp_rdy),
        .o_csr_rsp_rdata(rdata32), .o_csr_rsp_err(err32),
        .o_v_pmp_cfg(cfg32), .o_v_pmp_addr(addr32),
        .o_v_pmp_napot_mask(mask32), .o_pmp_upd_busy(busy32)
    );

    pmp_csr_file #(.PMP_CHANNEL_NUM(8), .ADDR_WIDTH(32)) dut8 (
        .i_clk(clk), .i_rst(rst),
        .i_csr_req_vld(vld8), .o_csr_req_rdy(rdy8), .i_csr_req_we(req_we),
        .i_csr_req_addr(req_addr), .i_csr_req_wdata(req_wdata),
        .o_csr_rsp_vld(rspv8), .i_csr_rsp_rdy(rsp_rdy),
        .o_csr_rsp_rdata(rdata8), .o_csr_rsp_err(err8),
        .o_v_pmp_cfg(cfg8), .o_v_pmp_addr(addr8),
        .o_v_pmp_napot_mask(mask8), .o_pmp_upd_busy(busy8)
    );

    // One request, issued at posedge+1 and accepted at the next edge; returns
    // at posedge+1 of the cycle in which the response is presented.
    task automatic do_req(input bit sel8, input bit we, input logic [11:0] addr,
                          input logic [31:0] wdata);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel8) vld8 = 1'b1;
        else      vld32 = 1'b1;
        @(posedge clk); #1;
        vld32 = 1'b0;
        vld8  = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] a_tab [6] = '{12'h3A0, 12'h3B5, 12'h300, 12'h3A8, 12'h3CF, 12'h3D0};
        logic        e_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (rspv32 !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %b exp 0", rspv32); end
        checks++; if (rdata32 !== 32'h0 || err32 !== 1'b0) begin errors++; $display("FAIL reset_rsp got %h/%b exp 0/0", rdata32, err32); end
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL reset_req_rdy got %b exp 1", rdy32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy32); end
        checks++; if (cfg32[0] !== 8'h00 || addr32[31] !== 32'h0) begin errors++; $display("FAIL reset_regs got %h/%h exp 0/0", cfg32[0], addr32[31]); end
        checks++; if (mask32[0] !== 32'hFFFF_FFFE || mask32[31] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL reset_mask got %h/%h exp fffffffe", mask32[0], mask32[31]); end
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, 1'b0, a_tab[i], 32'h0);
            checks++; if (rspv32 !== 1'b1 || rdata32 !== 32'h0 || err32 !== e_tab[i]) begin
                errors++; $display("FAIL reset_read %h got vld=%b rdata=%h err=%b exp 1/0/%b", a_tab[i], rspv32, rdata32, err32, e_tab[i]);
            end
        end
    endtask

    task automatic test_napot();
        do_req(1'b0, 1'b1, 12'h3B0, 32'h0000_0007);
        checks++; if (rspv32 !== 1'b1 || rdata32 !== 32'h0 || err32 !== 1'b0) begin errors++; $display("FAIL napot_wr_rsp got %b/%h/%b exp 1/0/0", rspv32, rdata32, err32); end
        checks++; if (busy32 !== PIPE) begin errors++; $display("FAIL napot_busy_t1 got %b exp %b", busy32, PIPE); end
        checks++; if (mask32[0] !== (PIPE ? 32'hFFFF_FFFE : 32'hFFFF_FFF0)) begin errors++; $display("FAIL napot_mask_t1 got %h exp %h", mask32[0], PIPE ? 32'hFFFF_FFFE : 32'hFFFF_FFF0); end
        @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL napot_busy_t2 got %b exp 0", busy32); end
        checks++; if (mask32[0] !== 32'hFFFF_FFF0) begin errors++; $display("FAIL napot_mask_t2 got %h exp fffffff0", mask32[0]); end
        do_req(1'b0, 1'b1, 12'h3B1, 32'hFFFF_FFFF);
        do_req(1'b0, 1'b0, 12'h3B0, 32'h0);
        checks++; if (rdata32 !== 32'h0000_0007) begin errors++; $display("FAIL napot_readback got %h exp 00000007", rdata32); end
        @(posedge clk); #1;
        checks++; if (mask32[1] !== 32'h0) begin errors++; $display("FAIL napot_allones_mask got %h exp 0", mask32[1]); end
    endtask

    task automatic test_cfg_lock();
        do_req(1'b0, 1'b1, 12'h3A0, 32'h0000_0082);
        do_req(1'b0, 1'b0, 12'h3A0, 32'h0);
        checks++; if (rdata32 !== 32'h0000_0080) begin errors++; $display("FAIL cfg_wr_noR got %h exp 00000080", rdata32); end
        do_req(1'b0, 1'b1, 12'h3A0, 32'h0000_0007);
        do_req(1'b0, 1'b0, 12'h3A0, 32'h0);
        checks++; if (rdata32 !== 32'h0000_0080) begin errors++; $display("FAIL cfg_locked_byte got %h exp 00000080", rdata32); end
        do_req(1'b0, 1'b1, 12'h3B0, 32'h0000_1234);
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL locked_addr_busy_t1 got %b exp 0", busy32); end
        @(posedge clk); #1;
        checks++; if (busy32 !== 1'b0 || addr32[0] !== 32'h7 || mask32[0] !== 32'hFFFF_FFF0) begin
            errors++; $display("FAIL locked_addr got busy=%b addr=%h mask=%h exp 0/7/fffffff0", busy32, addr32[0], mask32[0]);
        end
        do_req(1'b0, 1'b1, 12'h3A1, 32'hFF63_039D);
        do_req(1'b0, 1'b0, 12'h3A1, 32'h0);
        checks++; if (rdata32 !== 32'h9F03_039D) begin errors++; $display("FAIL cfg_warl_bytes got %h exp 9f03039d", rdata32); end
        checks++; if (cfg32[7] !== 8'h9F || cfg32[4] !== 8'h9D) begin errors++; $display("FAIL cfg_out got %h/%h exp 9f/9d", cfg32[7], cfg32[4]); end
    endtask

    task automatic test_tor_lock();
        do_req(1'b0, 1'b1, 12'h3A2, 32'h0000_8800);
        do_req(1'b0, 1'b1, 12'h3B8, 32'h0000_0111);
        do_req(1'b0, 1'b1, 12'h3BA, 32'h0000_0ABC);
        do_req(1'b0, 1'b1, 12'h3B9, 32'h0000_0222);
        @(posedge clk); #1;
        checks++; if (addr32[8] !== 32'h0) begin errors++; $display("FAIL tor_below_locked got %h exp 0", addr32[8]); end
        checks++; if (addr32[10] !== 32'h0ABC) begin errors++; $display("FAIL tor_above_write got %h exp 00000abc", addr32[10]); end
        checks++; if (addr32[9] !== 32'h0) begin errors++; $display("FAIL tor_self_locked got %h exp 0", addr32[9]); end
        do_req(1'b0, 1'b1, 12'h3A2, 32'h0000_0000);
        do_req(1'b0, 1'b0, 12'h3A2, 32'h0);
        checks++; if (rdata32 !== 32'h0000_8800) begin errors++; $display("FAIL lock_sticky got %h exp 00008800", rdata32); end
        do_req(1'b0, 1'b1, 12'h3A3, 32'h0000_0800);
        do_req(1'b0, 1'b1, 12'h3BC, 32'h0000_0055);
        @(posedge clk); #1;
        checks++; if (addr32[12] !== 32'h55) begin errors++; $display("FAIL tor_unlocked_write got %h exp 00000055", addr32[12]); end
    endtask

    task automatic test_backpressure();
        rsp_rdy = 1'b0;
        do_req(1'b0, 1'b0, 12'h3B0, 32'h0);
        checks++; if (rspv32 !== 1'b1 || rdata32 !== 32'h7) begin errors++; $display("FAIL bp_first got %b/%h exp 1/00000007", rspv32, rdata32); end
        req_addr = 12'h3BA;
        vld32    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (rdy32 !== 1'b0 || rspv32 !== 1'b1 || rdata32 !== 32'h7 || err32 !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc%0d got rdy=%b vld=%b rdata=%h exp 0/1/00000007", c, rdy32, rspv32, rdata32);
            end
            @(posedge clk); #1;
        end
        rsp_rdy = 1'b1;
        #1;
        checks++; if (rdy32 !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b exp 1", rdy32); end
        @(posedge clk); #1;
        vld32 = 1'b0;
        checks++; if (rspv32 !== 1'b1 || rdata32 !== 32'h0ABC) begin errors++; $display("FAIL bp_next got %b/%h exp 1/00000abc", rspv32, rdata32); end
        @(posedge clk); #1;
        checks++; if (rspv32 !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", rspv32); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 1'b1, 12'h3B3, 32'h0000_0003);
        checks++; if (rspv32 !== 1'b1 || busy32 !== PIPE) begin errors++; $display("FAIL b2b_w1 got vld=%b busy=%b exp 1/%b", rspv32, busy32, PIPE); end
        do_req(1'b0, 1'b1, 12'h3B3, 32'h0000_000F);
        checks++; if (rspv32 !== 1'b1 || busy32 !== PIPE) begin errors++; $display("FAIL b2b_w2 got vld=%b busy=%b exp 1/%b", rspv32, busy32, PIPE); end
        do_req(1'b0, 1'b0, 12'h3B3, 32'h0);
        checks++; if (rspv32 !== 1'b1 || rdata32 !== 32'h0000_000F) begin errors++; $display("FAIL b2b_raw got %b/%h exp 1/0000000f", rspv32, rdata32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy32); end
        checks++; if (mask32[3] !== 32'hFFFF_FFE0) begin errors++; $display("FAIL b2b_mask got %h exp ffffffe0", mask32[3]); end
    endtask

    task automatic test_small_n();
        logic [11:0] a_tab [4] = '{12'h3A2, 12'h3BA, 12'h3A1, 12'h3B7};
        logic [31:0] w_tab [4] = '{32'hFFFF_FFFF, 32'h0000_0055, 32'h0101_0101, 32'h0000_0001};
        logic [31:0] r_tab [4] = '{32'h0, 32'h0, 32'h0101_0101, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 1'b1, a_tab[i], w_tab[i]);
            checks++; if (rspv8 !== 1'b1 || err8 !== 1'b0) begin errors++; $display("FAIL small_wr %h got vld=%b err=%b exp 1/0", a_tab[i], rspv8, err8); end
            do_req(1'b1, 1'b0, a_tab[i], 32'h0);
            checks++; if (rdata8 !== r_tab[i] || err8 !== 1'b0) begin errors++; $display("FAIL small_rd %h got %h/%b exp %h/0", a_tab[i], rdata8, err8, r_tab[i]); end
        end
        checks++; if (cfg8[4] !== 8'h01 || addr8[7] !== 32'h1) begin errors++; $display("FAIL small_out got %h/%h exp 01/00000001", cfg8[4], addr8[7]); end
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        do_req(1'b1, 1'b0, 12'h3B7, 32'h0);
        checks++; if (rspv8 !== 1'b1 || rdata8 !== 32'h1) begin errors++; $display("FAIL small_pend got %b/%h exp 1/00000001", rspv8, rdata8); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (rspv8 !== 1'b0 || rdata8 !== 32'h0 || err8 !== 1'b0) begin errors++; $display("FAIL midrst_rsp got %b/%h/%b exp 0/0/0", rspv8, rdata8, err8); end
        checks++; if (cfg8[4] !== 8'h00 || addr8[7] !== 32'h0 || mask8[7] !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL midrst_regs got %h/%h/%h exp 00/0/fffffffe", cfg8[4], addr8[7], mask8[7]);
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (rspv8 !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("FAIL midrst_after got %b/%b exp 0/0", rspv8, busy8); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_napot();
        test_cfg_lock();
        test_tor_lock();
        test_backpressure();
        test_back_to_back();
        test_small_n();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
